led_matrix_column_scanner: RTL and testbench
============================================

Name: led_matrix_column_scanner

Overview:
Time-multiplexed driver for the 5x7 LED matrix. It consumes the 7-bit row images produced by the per-column irrigation status decoders, concatenated into one 35-bit vector. It scans one column at a time with a blanking gap between columns to suppress ghosting, and drives the physical column-select and row lines. The image is snapshotted once per frame, so the display never tears.

Parameters:
NUM_COLS, 5, number of matrix columns scanned
NUM_ROWS, 7, rows per column
DWELL_CYCLES, 1000, clock cycles each column is driven (>=1)
BLANK_CYCLES, 2, clock cycles all columns are off before each column (>=1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
enable  input  1  scan enable; low forces blank output and restarts the frame
image_in  input  NUM_COLS*NUM_ROWS  image_in[c*NUM_ROWS+r] = row r of column c, from the status decoders
col_n  output  NUM_COLS  column select, active-low, at most one bit low
rows  output  NUM_ROWS  row drive, active-high, for the selected column
frame_done  output  1  one-cycle pulse on the last drive cycle of the last column

Behaviour:
- One clock and one reset. Reset is asynchronous and active-high.
- All outputs are registered/Moore, derived from the state registers only. No combinational path from any input to any output.
- Reset (async assert, immediate): state=BLANK, col_idx=0, cnt=0, shadow=0, col_n=all ones, rows=0, frame_done=0.
- FSM states:
  - BLANK: col_n=all ones, rows=0.
  - DRIVE: col_n[col_idx]=0 and all other bits 1; rows=shadow column col_idx.
- BLANK: cnt counts 0..BLANK_CYCLES-1. At the end it goes to DRIVE with cnt=0.
- DRIVE: cnt counts 0..DWELL_CYCLES-1. At the end it goes to BLANK with cnt=0, and col_idx increments, wrapping from NUM_COLS-1 to 0.
- Frame snapshot: shadow<=image_in on any edge where state=BLANK, col_idx=0, cnt=0 and enable=1.
  - image_in changes mid-frame have no visible effect until the next frame.
- Timing: the first enabled cycle after reset release is frame cycle 0.
  - Column c is driven on frame cycles c*(B+D)+B .. c*(B+D)+B+D-1, where B=BLANK_CYCLES and D=DWELL_CYCLES.
  - Frame length is NUM_COLS*(B+D) cycles, back-to-back with no idle gap.
- frame_done=1 only while state=DRIVE, col_idx=NUM_COLS-1, cnt=DWELL_CYCLES-1. Otherwise 0.
- enable=0, sampled at an edge: next state is BLANK, col_idx=0, cnt=0. Outputs are blank from that edge onward and frame_done=0.
  - On re-enable, a fresh frame starts with a fresh snapshot.
- enable toggling inside a single cycle is not special-cased; only the value sampled at the edge matters.
- Counter widths are $clog2 of the respective parameter, minimum 1 bit. Counters never exceed their terminal value.
- Reset asserted mid-DRIVE blanks the outputs immediately, without waiting for a clock edge.
- Invariant: col_n never has more than one bit low. col_n is all ones in every BLANK cycle.

Test Plan:
Bench configuration: NUM_COLS=5, NUM_ROWS=7, B=2, D=4, frame=30 cycles.
- Reset: assert reset with clk stopped -> col_n=5'b11111, rows=7'h00, frame_done=0 immediately. Same values hold for all reset cycles.
- Static image: col0=7'b1000001, col1=7'b0111110, col2=7'h7F, col3=7'h00, col4=7'b0101010, enable=1 ->
  - cycles 0-1: blank;
  - cycles 2-5: col_n=5'b11110, rows=7'b1000001;
  - cycles 8-11: col_n=5'b11101, rows=7'b0111110;
  - cycles 26-29: col_n=5'b01111, rows=7'b0101010;
  - pattern repeats from cycle 30.
- Tear-free update: change col0 to 7'h00 at cycle 10 -> cycles 2-5 of frame 1 unaffected; cycles 32-35 show rows=7'h00.
- frame_done: exactly one pulse per frame, at cycles 29, 59 and 89; zero elsewhere, including all BLANK cycles.
- Enable drop: enable=0 at cycle 14 (col2 DRIVE) -> blank from that edge. Re-enable at cycle 20 -> cycles 20-21 blank, col0 driven at cycles 22-25 with the image present at cycle 20.
- Async reset mid-DRIVE: pulse reset at cycle 4.5 -> outputs blank at once. After release, timing restarts from frame cycle 0 and shadow is re-loaded.

Source files
------------

// File: rtl/led_matrix_column_scanner_if.sv
// led_matrix_column_scanner_if: image/enable inputs and matrix drive lines of the column scanner
interface led_matrix_column_scanner_if #(
    parameter int NUM_COLS = 5,
    parameter int NUM_ROWS = 7
);
    logic                         enable;
    logic [NUM_COLS*NUM_ROWS-1:0] image_in;
    logic [NUM_COLS-1:0]          col_n;
    logic [NUM_ROWS-1:0]          rows;
    logic                         frame_done;
    modport master (output enable, image_in, input col_n, rows, frame_done);
    modport slave (input enable, image_in, output col_n, rows, frame_done);
endinterface

// File: rtl/led_matrix_column_scanner.sv
// led_matrix_column_scanner: blanked, tear-free column scan of a NUM_COLS x NUM_ROWS LED matrix
module led_matrix_column_scanner #(
    parameter int NUM_COLS     = 5,
    parameter int NUM_ROWS     = 7,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    led_matrix_column_scanner_if.slave bus
);
    localparam int CW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;
    localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
    localparam int DW = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
    typedef enum logic {BLANK, DRIVE} state_t;
    state_t                       state, state_n;
    logic [CW-1:0]                col_idx, col_idx_n;
    logic [BW-1:0]                bcnt, bcnt_n;
    logic [DW-1:0]                dcnt, dcnt_n;
    logic [NUM_COLS*NUM_ROWS-1:0] shadow, shadow_n;
    logic [NUM_COLS-1:0]          col_n_n;
    logic [NUM_ROWS-1:0]          rows_n;
    logic                         fd_n, b_last, d_last, c_last;
    assign b_last = bcnt == BW'(BLANK_CYCLES - 1);
    assign d_last = dcnt == DW'(DWELL_CYCLES - 1);
    assign c_last = col_idx == CW'(NUM_COLS - 1);
    // Outputs are registered from the next-state values so they line up with the state they describe
    always_comb begin
        state_n   = state;
        col_idx_n = col_idx;
        bcnt_n    = bcnt;
        dcnt_n    = dcnt;
        shadow_n  = shadow;
        if (!bus.enable) begin
            state_n   = BLANK;
            col_idx_n = '0;
            bcnt_n    = '0;
            dcnt_n    = '0;
        end else if (state == BLANK) begin
            if (col_idx == '0 && bcnt == '0) shadow_n = bus.image_in;
            state_n = b_last ? DRIVE : BLANK;
            bcnt_n  = b_last ? '0 : bcnt + 1'b1;
        end else begin
            state_n   = d_last ? BLANK : DRIVE;
            dcnt_n    = d_last ? '0 : dcnt + 1'b1;
            col_idx_n = !d_last ? col_idx : c_last ? '0 : col_idx + 1'b1;
        end
        col_n_n = state_n == DRIVE ? ~(NUM_COLS'(1) << col_idx_n) : '1;
        rows_n  = state_n == DRIVE ? shadow_n[int'(col_idx_n)*NUM_ROWS +: NUM_ROWS] : '0;
        fd_n    = state_n == DRIVE && col_idx_n == CW'(NUM_COLS - 1) && dcnt_n == DW'(DWELL_CYCLES - 1);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= BLANK;
            col_idx        <= '0;
            bcnt           <= '0;
            dcnt           <= '0;
            shadow         <= '0;
            bus.col_n      <= '1;
            bus.rows       <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= state_n;
            col_idx        <= col_idx_n;
            bcnt           <= bcnt_n;
            dcnt           <= dcnt_n;
            shadow         <= shadow_n;
            bus.col_n      <= col_n_n;
            bus.rows       <= rows_n;
            bus.frame_done <= fd_n;
        end
    end
endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// tb_led_matrix_column_scanner: directed vectors for a 5x7 scanner with B=2, D=4 (30-cycle frame)
module tb_led_matrix_column_scanner;
    typedef struct {
        int         ph;
        int         cyc;
        logic [4:0] col_n;
        logic [6:0] rows;
        logic       fd;
    } vec_t;
    localparam logic [34:0] IMG0 = {7'h2A, 7'h00, 7'h7F, 7'h3E, 7'h41};
    logic clk = 1'b0, reset = 1'b0, clk_en = 1'b0;
    int checks = 0, errors = 0;
    logic [4:0] gc[0:3][0:99];
    logic [6:0] gr[0:3][0:99];
    logic       gf[0:3][0:99];
    vec_t tbl[$];
    led_matrix_column_scanner_if #(.NUM_COLS(5), .NUM_ROWS(7)) bus ();
    led_matrix_column_scanner #(.NUM_COLS(5), .NUM_ROWS(7), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 if (clk_en) clk = ~clk;

    function automatic vec_t v(input int ph, input int cyc, input logic [4:0] cn, input logic [6:0] r, input logic f);
        vec_t x;
        x.ph = ph; x.cyc = cyc; x.col_n = cn; x.rows = r; x.fd = f;
        return x;
    endfunction

    task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic sample(input int ph, input int c);
        gc[ph][c] = bus.col_n;
        gr[ph][c] = bus.rows;
        gf[ph][c] = bus.frame_done;
        chk("one_col_low", c, 32'($countones(~bus.col_n) <= 1), 32'(1));
    endtask

    task automatic start_frame();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        // phase 0: static image with col0 cleared at cycle 10 (visible only from frame 1)
        tbl.push_back(v(0, 0, 5'h1F, 7'h00, 0));  tbl.push_back(v(0, 1, 5'h1F, 7'h00, 0));
        tbl.push_back(v(0, 2, 5'h1E, 7'h41, 0));  tbl.push_back(v(0, 5, 5'h1E, 7'h41, 0));
        tbl.push_back(v(0, 6, 5'h1F, 7'h00, 0));  tbl.push_back(v(0, 7, 5'h1F, 7'h00, 0));
        tbl.push_back(v(0, 8, 5'h1D, 7'h3E, 0));  tbl.push_back(v(0, 11, 5'h1D, 7'h3E, 0));
        tbl.push_back(v(0, 14, 5'h1B, 7'h7F, 0)); tbl.push_back(v(0, 20, 5'h17, 7'h00, 0));
        tbl.push_back(v(0, 26, 5'h0F, 7'h2A, 0)); tbl.push_back(v(0, 29, 5'h0F, 7'h2A, 1));
        tbl.push_back(v(0, 30, 5'h1F, 7'h00, 0)); tbl.push_back(v(0, 32, 5'h1E, 7'h00, 0));
        tbl.push_back(v(0, 35, 5'h1E, 7'h00, 0)); tbl.push_back(v(0, 38, 5'h1D, 7'h3E, 0));
        tbl.push_back(v(0, 59, 5'h0F, 7'h2A, 1)); tbl.push_back(v(0, 62, 5'h1E, 7'h00, 0));
        tbl.push_back(v(0, 89, 5'h0F, 7'h2A, 1));
        // phase 1: enable low on cycles 14..19, col0 becomes 7'h55 while disabled
        tbl.push_back(v(1, 2, 5'h1E, 7'h41, 0));  tbl.push_back(v(1, 8, 5'h1D, 7'h3E, 0));
        tbl.push_back(v(1, 14, 5'h1B, 7'h7F, 0)); tbl.push_back(v(1, 15, 5'h1F, 7'h00, 0));
        tbl.push_back(v(1, 19, 5'h1F, 7'h00, 0)); tbl.push_back(v(1, 20, 5'h1F, 7'h00, 0));
        tbl.push_back(v(1, 21, 5'h1F, 7'h00, 0)); tbl.push_back(v(1, 22, 5'h1E, 7'h55, 0));
        tbl.push_back(v(1, 25, 5'h1E, 7'h55, 0)); tbl.push_back(v(1, 26, 5'h1F, 7'h00, 0));
        tbl.push_back(v(1, 28, 5'h1D, 7'h3E, 0)); tbl.push_back(v(1, 49, 5'h0F, 7'h2A, 1));
        // phases 2/3: before and after an async reset pulse mid-DRIVE, col0 becomes 7'h11 during reset
        tbl.push_back(v(2, 2, 5'h1E, 7'h41, 0));  tbl.push_back(v(2, 4, 5'h1E, 7'h41, 0));
        tbl.push_back(v(3, 0, 5'h1F, 7'h00, 0));  tbl.push_back(v(3, 1, 5'h1F, 7'h00, 0));
        tbl.push_back(v(3, 2, 5'h1E, 7'h11, 0));  tbl.push_back(v(3, 5, 5'h1E, 7'h11, 0));
        tbl.push_back(v(3, 6, 5'h1F, 7'h00, 0));  tbl.push_back(v(3, 8, 5'h1D, 7'h3E, 0));

        bus.enable   = 1'b1;
        bus.image_in = IMG0;
        #10 reset = 1'b1;
        #1;
        chk("rst_stopped_col_n", 0, 32'(bus.col_n), 32'(5'h1F));
        chk("rst_stopped_rows", 0, 32'(bus.rows), 32'(0));
        chk("rst_stopped_fd", 0, 32'(bus.frame_done), 32'(0));
        clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_col_n", i, 32'(bus.col_n), 32'(5'h1F));
            chk("rst_rows", i, 32'(bus.rows), 32'(0));
            chk("rst_fd", i, 32'(bus.frame_done), 32'(0));
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 90; c++) begin
            if (c == 10) bus.image_in[6:0] = 7'h00;
            @(negedge clk);
            sample(0, c);
            chk("p0_frame_done", c, 32'(bus.frame_done), 32'(c % 30 == 29));
            @(posedge clk);
            #1;
        end

        bus.image_in = IMG0;
        start_frame();
        for (int c = 0; c < 50; c++) begin
            bus.enable = !(c >= 14 && c <= 19);
            if (c == 17) bus.image_in[6:0] = 7'h55;
            @(negedge clk);
            sample(1, c);
            chk("p1_frame_done", c, 32'(bus.frame_done), 32'(c == 49));
            @(posedge clk);
            #1;
        end

        bus.enable   = 1'b1;
        bus.image_in = IMG0;
        start_frame();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            sample(2, c);
            if (c < 4) begin
                @(posedge clk);
                #1;
            end
        end
        reset = 1'b1;
        #1;
        chk("async_rst_col_n", 4, 32'(bus.col_n), 32'(5'h1F));
        chk("async_rst_rows", 4, 32'(bus.rows), 32'(0));
        chk("async_rst_fd", 4, 32'(bus.frame_done), 32'(0));
        bus.image_in[6:0] = 7'h11;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            sample(3, c);
            chk("p3_frame_done", c, 32'(bus.frame_done), 32'(0));
            @(posedge clk);
            #1;
        end

        foreach (tbl[i]) begin
            chk($sformatf("p%0d_col_n", tbl[i].ph), tbl[i].cyc, 32'(gc[tbl[i].ph][tbl[i].cyc]), 32'(tbl[i].col_n));
            chk($sformatf("p%0d_rows", tbl[i].ph), tbl[i].cyc, 32'(gr[tbl[i].ph][tbl[i].cyc]), 32'(tbl[i].rows));
            chk($sformatf("p%0d_fd", tbl[i].ph), tbl[i].cyc, 32'(gf[tbl[i].ph][tbl[i].cyc]), 32'(tbl[i].fd));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
